// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// A 32-step shift-add multiply or a restoring divide runs on operand
// magnitudes. A single fix-up cycle then applies the sign and selects the
// result word. stall_o freezes the core while an operation is in flight.
// The divider is built only when the macro MULDIV_DIV_EN is defined.
// Without it, ops 100-111 complete in one cycle with a zero result.
`timescale 1ns/1ps
module muldiv_seq (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o
);
   localparam int DATA_W = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   // Two's-complement negate when neg is set (magnitude and sign fix-up).
   function automatic logic [DATA_W-1:0] cond_neg32(input logic signed [DATA_W-1:0] v,
                                                    input logic neg);
      return neg ? DATA_W'(-v) : DATA_W'(v);
   endfunction

   function automatic logic [2*DATA_W-1:0] cond_neg64(input logic signed [2*DATA_W-1:0] v,
                                                      input logic neg);
      return neg ? (2*DATA_W)'(-v) : (2*DATA_W)'(v);
   endfunction

   logic [1:0]          state_q;
   logic [5:0]          cnt_q;
   logic [2:0]          op_q;
   logic                sign_a_q, sign_b_q;
   logic [2*DATA_W-1:0] acc_q;    // mul: product; div: {remainder, dividend/quotient}
   logic [2*DATA_W-1:0] opb_q;    // mul: shifted multiplicand; div: divisor in low word
   logic [DATA_W-1:0]   mplr_q;   // remaining multiplier bits, LSB first
   logic [DATA_W-1:0]   result_q;

   logic                a_signed, b_signed, sign_a, sign_b;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic                special;
   logic [DATA_W-1:0]   special_res;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   fix_res;

   // Operand signedness and magnitudes for the accepting cycle
   always_comb begin
      a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
      b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      sign_a   = a_signed & rs1_i[DATA_W-1];
      sign_b   = b_signed & rs2_i[DATA_W-1];
      mag_a    = cond_neg32(rs1_i, sign_a);
      mag_b    = cond_neg32(rs2_i, sign_b);
   end

`ifdef MULDIV_DIV_EN
   logic                div_zero, div_ovf;
   logic [DATA_W+1:0]   div_diff;

   // Divide-by-zero and signed overflow bypass the iteration entirely
   always_comb begin
      div_zero    = op_i[2] && (rs2_i == '0);
      div_ovf     = op_i[2] && !op_i[0] && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
      special     = div_zero || div_ovf;
      special_res = '0;
      if (div_zero)
         special_res = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
      else if (div_ovf)
         special_res = op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
   end

   // Restoring trial subtract: {remainder, next dividend bit} minus divisor
   always_comb begin
      div_diff = {1'b0, acc_q[2*DATA_W-1:DATA_W-1]} - {2'b00, opb_q[DATA_W-1:0]};
   end
`else
   // Divide ops return zero immediately when the divider is not built
   always_comb begin
      special     = op_i[2];
      special_res = '0;
   end
`endif

   // Sign correction and result word selection for the fix-up cycle
   always_comb begin
      prod    = cond_neg64(acc_q, sign_a_q ^ sign_b_q);
      fix_res = (op_q == OP_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
`ifdef MULDIV_DIV_EN
      if (op_q[2]) begin
         if (op_q[1])
            fix_res = cond_neg32(acc_q[2*DATA_W-1:DATA_W], sign_a_q);
         else
            fix_res = cond_neg32(acc_q[DATA_W-1:0], sign_a_q ^ sign_b_q);
      end
`endif
   end

   // Sequencer control, iteration counter and the registered result
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  cnt_q <= '0;
                  if (special) begin
                     result_q <= special_res;
                     state_q  <= S_DONE;
                  end else begin
                     state_q  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'd31)
                  state_q <= S_FIX;
            end
            S_FIX: begin
               result_q <= fix_res;
               state_q  <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Datapath: operand capture on accept, one multiply/divide step per CALC cycle
   always_ff @(posedge clk_i) begin
      if (state_q == S_IDLE && start_i) begin
         op_q     <= op_i;
         sign_a_q <= sign_a;
         sign_b_q <= sign_b;
         if (op_i[2]) begin
            acc_q <= {{DATA_W{1'b0}}, mag_a};
            opb_q <= {{DATA_W{1'b0}}, mag_b};
         end else begin
            acc_q <= '0;
            opb_q <= {{DATA_W{1'b0}}, mag_a};
         end
         mplr_q <= mag_b;
      end else if (state_q == S_CALC) begin
`ifdef MULDIV_DIV_EN
         if (op_q[2]) begin
            if (!div_diff[DATA_W+1])
               acc_q <= {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            else
               acc_q <= {acc_q[2*DATA_W-2:0], 1'b0};
         end else
`endif
         begin
            if (mplr_q[0])
               acc_q <= acc_q + opb_q;
            opb_q  <= {opb_q[2*DATA_W-2:0], 1'b0};
            mplr_q <= {1'b0, mplr_q[DATA_W-1:1]};
         end
      end
   end

   // Output decode; stall is gated by reset so it never leaks out during reset
   always_comb begin
      busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
      done_o   = (state_q == S_DONE);
      stall_o  = rst_i && (((state_q == S_IDLE) && start_i) || busy_o);
      result_o = result_q;
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq.
// Expected results come from a behavioural model built on integer
// arithmetic. The bench follows the MULDIV_DIV_EN setting of the build.
`timescale 1ns/1ps
module tb_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_i, rs2_i;
   logic        stall_o, busy_o, done_o;
   logic [31:0] result_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_seq dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start_i),
      .op_i    (op_i),
      .rs1_i   (rs1_i),
      .rs2_i   (rs2_i),
      .stall_o (stall_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .result_o(result_o)
   );

   // Reference result from RV32M semantics
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa = longint'(signed'(a));
      longint sb = longint'(signed'(b));
      longint ua = longint'({32'h0, a});
      longint ub = longint'({32'h0, b});
      int     ia = a;
      int     ib = b;
      logic [63:0] p;
      logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = 64'(ua * ub); return p[31:0];  end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         default: ;
      endcase
`ifdef MULDIV_DIV_EN
      case (op)
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
         default: return (b == 0) ? a : a % b;
      endcase
`else
      return 32'h0;
`endif
   endfunction

   // Reference latency: cycle index (after the accept cycle 0) of done_o
   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (!op[2]) return 34;
`ifdef MULDIV_DIV_EN
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
`else
      return 1;
`endif
   endfunction

   // Directed divide expectations collapse to zero when the divider is absent
   function automatic logic [31:0] dv(input logic [31:0] v);
`ifdef MULDIV_DIV_EN
      return v;
`else
      return 32'h0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete operation; optional extra start pulse at cycle pulse_at
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int pulse_at);
      int c, nst, nbz, lat;
      logic [31:0] held;
      lat = ref_latency(op, a, b);
      op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
      #1;
      check({tag, ".stall_c0"}, 32'(stall_o), 32'h1);
      @(posedge clk); #1;
      start_i = 1'b0;
      op_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
      c = 1; nst = 0; nbz = 0;
      while (done_o !== 1'b1 && c < 60) begin
         if (stall_o === 1'b1) nst++;
         if (busy_o === 1'b1) nbz++;
         if (c == pulse_at) begin
            start_i = 1'b1; op_i = ~op; rs1_i = $urandom; rs2_i = $urandom;
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      start_i = 1'b0;
      check({tag, ".latency"}, 32'(c), 32'(lat));
      check({tag, ".result"}, result_o, exp);
      check({tag, ".stall_done"}, 32'(stall_o), 32'h0);
      check({tag, ".stall_cycles"}, 32'(nst), 32'(lat - 1));
      check({tag, ".busy_cycles"}, 32'(nbz), 32'(lat - 1));
      held = result_o;
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 32'(done_o), 32'h0);
      check({tag, ".result_hold"}, result_o, exp);
      if (held !== exp) ;
   endtask

   initial begin
      logic seen_done;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      // Reset state, with start held high to show stall is gated
      rst_i = 1'b0; start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd1; rs2_i = 32'd1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.stall", 32'(stall_o), 32'h0);
      check("rst.busy", 32'(busy_o), 32'h0);
      check("rst.done", 32'(done_o), 32'h0);
      check("rst.result", result_o, 32'h0);
      start_i = 1'b0; rst_i = 1'b1;
      @(posedge clk); #1;

      // Multiply family
      run_op("mul_7xm3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, -1);
      run_op("mulhu_ffff",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
      run_op("mulh_ffff",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, -1);
      run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, -1);

      // Divide family, -7 by 2
      run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFD), -1);
      run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFF), -1);
      run_op("divu_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2, dv(32'h7FFF_FFFC), -1);
      run_op("remu_m7_2", 3'd7, 32'hFFFF_FFF9, 32'd2, dv(32'h0000_0001), -1);

      // Special divide cases
      run_op("divu_5_0", 3'd5, 32'd5,         32'd0,         dv(32'hFFFF_FFFF), -1);
      run_op("remu_5_0", 3'd7, 32'd5,         32'd0,         dv(32'h0000_0005), -1);
      run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), -1);
      run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0000_0000), -1);
      run_op("div_100_7", 3'd4, 32'd100,      32'd7,         dv(32'd14),        -1);

      // Start pulse during a running operation is ignored
      run_op("mul_busy_start", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);

      // Reset at cycle 10 aborts the operation
      op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_i = 1'b0;
      #1;
      check("abort.stall", 32'(stall_o), 32'h0);
      check("abort.busy", 32'(busy_o), 32'h0);
      check("abort.done", 32'(done_o), 32'h0);
      check("abort.result", result_o, 32'h0);
      seen_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done_o !== 1'b0) seen_done = 1'b1;
      end
      rst_i = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_o !== 1'b0) seen_done = 1'b1;
      end
      check("abort.no_done", 32'(seen_done), 32'h0);
      run_op("mul_3x4_after_rst", 3'd0, 32'd3, 32'd4, 32'h0000_000C, -1);

      // Randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom);
         ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ref_result(rop, ra, rb), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
